sobel_frame_ctrl: RTL and testbench

Frame sequencer for the grayscale/Sobel pipeline. On start, it streams one frame of RGB pixels from a source memory into the RGB FIFO. Concurrently it drains the Sobel FIFO into a destination memory, then signals done. It sits between the frame memories and the dut_system FIFO ports and owns all address generation and flow control for one frame.

---
 rtl/sobel_frame_ctrl.sv | 175 +++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl
//   Frame sequencer for the grayscale/Sobel pipeline. A start request in IDLE
//   streams one frame of RGB pixels from the source memory into the RGB FIFO,
//   while the Sobel FIFO is drained concurrently into the destination memory.
//   Once the last result is written the block reports done and returns to IDLE.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous active-low reset
//   start            one-cycle frame request, honoured only in IDLE
//   busy             high in RUN and DONE
//   done             one-cycle pulse after the last destination write
//   src_rd_en        source memory read strobe
//   src_addr         source read address
//   src_rd_data      source data, valid one cycle after src_rd_en
//   fifo_rgb_wr_en   push strobe into the RGB FIFO
//   fifo_rgb_din     pixel pushed into the RGB FIFO
//   fifo_rgb_full    RGB FIFO full
//   fifo_sobel_rd_en pop strobe from the Sobel FIFO
//   fifo_sobel_dout  Sobel FIFO head (first-word-fall-through)
//   fifo_sobel_empty Sobel FIFO empty
//   dst_wr_en        destination write strobe
//   dst_addr         destination write address
//   dst_wr_data      destination write data
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH    = 720,
  parameter int IMG_HEIGHT   = 540,
  parameter int RGB_DWIDTH   = 24,
  parameter int SOBEL_DWIDTH = 8,
  parameter int ADDR_WIDTH   = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    src_rd_en,
  output logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [RGB_DWIDTH-1:0]   src_rd_data,
  output logic                    fifo_rgb_wr_en,
  output logic [RGB_DWIDTH-1:0]   fifo_rgb_din,
  input  logic                    fifo_rgb_full,
  output logic                    fifo_sobel_rd_en,
  input  logic [SOBEL_DWIDTH-1:0] fifo_sobel_dout,
  input  logic                    fifo_sobel_empty,
  output logic                    dst_wr_en,
  output logic [ADDR_WIDTH-1:0]   dst_addr,
  output logic [SOBEL_DWIDTH-1:0] dst_wr_data
);

  // Counters carry one extra bit so the terminal value N is representable
  // even when N equals 2^ADDR_WIDTH.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         NPIX      = CW'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [CW-1:0]         ONE       = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]           pop_cnt_q, pop_cnt_d;
  logic                    inflight_q, inflight_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [RGB_DWIDTH-1:0]   hold_data_q, hold_data_d;
  logic                    dst_wr_en_q, dst_wr_en_d;
  logic [ADDR_WIDTH-1:0]   dst_addr_q, dst_addr_d;
  logic [SOBEL_DWIDTH-1:0] dst_wr_data_q, dst_wr_data_d;

  always_comb begin
    state_d          = state_q;
    rd_cnt_d         = rd_cnt_q;
    pop_cnt_d        = pop_cnt_q;
    inflight_d       = 1'b0;
    hold_valid_d     = hold_valid_q;
    hold_data_d      = hold_data_q;
    dst_wr_en_d      = 1'b0;
    dst_addr_d       = dst_addr_q;
    dst_wr_data_d    = dst_wr_data_q;
    src_rd_en        = 1'b0;
    fifo_rgb_wr_en   = 1'b0;
    fifo_rgb_din     = '0;
    fifo_sobel_rd_en = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RUN;
          rd_cnt_d     = '0;
          pop_cnt_d    = '0;
          hold_valid_d = 1'b0;
        end
      end

      S_RUN: begin
        // At most one pixel is ever owned by this block (in flight or held),
        // so the hold register never overflows.
        src_rd_en = (rd_cnt_q < NPIX) && !hold_valid_q && !(inflight_q && fifo_rgb_full);
        if (src_rd_en) begin
          rd_cnt_d = rd_cnt_q + ONE;
        end
        inflight_d = src_rd_en;

        // The issue rule keeps inflight and hold_valid mutually exclusive.
        if (hold_valid_q && !fifo_rgb_full) begin
          fifo_rgb_wr_en = 1'b1;
          fifo_rgb_din   = hold_data_q;
          hold_valid_d   = 1'b0;
        end else if (inflight_q && !hold_valid_q && !fifo_rgb_full) begin
          fifo_rgb_wr_en = 1'b1;
          fifo_rgb_din   = src_rd_data;
        end else if (inflight_q) begin
          hold_data_d  = src_rd_data;
          hold_valid_d = 1'b1;
        end

        fifo_sobel_rd_en = !fifo_sobel_empty && (pop_cnt_q < NPIX);
        if (fifo_sobel_rd_en) begin
          dst_wr_en_d   = 1'b1;
          dst_addr_d    = pop_cnt_q[ADDR_WIDTH-1:0];
          dst_wr_data_d = fifo_sobel_dout;
          pop_cnt_d     = pop_cnt_q + ONE;
        end

        if (dst_wr_en_q && (dst_addr_q == LAST_ADDR)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rd_cnt_q      <= '0;
      pop_cnt_q     <= '0;
      inflight_q    <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_data_q   <= '0;
      dst_wr_en_q   <= 1'b0;
      dst_addr_q    <= '0;
      dst_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      pop_cnt_q     <= pop_cnt_d;
      inflight_q    <= inflight_d;
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      dst_wr_en_q   <= dst_wr_en_d;
      dst_addr_q    <= dst_addr_d;
      dst_wr_data_q <= dst_wr_data_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign src_addr    = rd_cnt_q[ADDR_WIDTH-1:0];
  assign dst_wr_en   = dst_wr_en_q;
  assign dst_addr    = dst_addr_q;
  assign dst_wr_data = dst_wr_data_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Testbench for sobel_frame_ctrl on a 4x4 frame. A behavioural model tracks
// how many pixels the controller currently owns and when they were fetched,
// plus the pop/write sequence, and is compared against the DUT every cycle.
module tb_sobel_frame_ctrl;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int RW = 24;
  localparam int SW = 8;
  localparam int AW = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          src_rd_en;
  logic [AW-1:0] src_addr;
  logic [RW-1:0] src_rd_data;
  logic          fifo_rgb_wr_en;
  logic [RW-1:0] fifo_rgb_din;
  logic          fifo_rgb_full;
  logic          fifo_sobel_rd_en;
  logic [SW-1:0] fifo_sobel_dout;
  logic          fifo_sobel_empty;
  logic          dst_wr_en;
  logic [AW-1:0] dst_addr;
  logic [SW-1:0] dst_wr_data;

  sobel_frame_ctrl #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .RGB_DWIDTH  (RW),
    .SOBEL_DWIDTH(SW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .src_rd_en       (src_rd_en),
    .src_addr        (src_addr),
    .src_rd_data     (src_rd_data),
    .fifo_rgb_wr_en  (fifo_rgb_wr_en),
    .fifo_rgb_din    (fifo_rgb_din),
    .fifo_rgb_full   (fifo_rgb_full),
    .fifo_sobel_rd_en(fifo_sobel_rd_en),
    .fifo_sobel_dout (fifo_sobel_dout),
    .fifo_sobel_empty(fifo_sobel_empty),
    .dst_wr_en       (dst_wr_en),
    .dst_addr        (dst_addr),
    .dst_wr_data     (dst_wr_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Behavioural model state: 0 idle, 1 run, 2 done
  int phase, reads, pushes, last_iss, pops, writes, wr_idx;
  bit wr_pending;
  logic [SW-1:0] wr_val;

  logic [RW-1:0] src_mem [N];
  logic [SW-1:0] sob_mem [N];

  // Environment knobs
  int full_pct, empty_pct, force_lo, force_hi;
  bit empty_tog;

  // Next-cycle environment inputs
  logic [RW-1:0] nxt_src;
  logic [SW-1:0] nxt_dout;
  logic          nxt_full, nxt_empty;

  // Per-frame observations
  int f_rd, f_wr, f_done, f_first_rd, f_last_rd, f_first_push, f_done_cyc, f_start_cyc, f_first_addr;
  logic [SW-1:0] f_last_wdata;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_src_rd_en"}, src_rd_en, 0);
    chk({pfx, "_src_addr"}, src_addr, 0);
    chk({pfx, "_rgb_wr_en"}, fifo_rgb_wr_en, 0);
    chk({pfx, "_rgb_din"}, fifo_rgb_din, 0);
    chk({pfx, "_sobel_rd_en"}, fifo_sobel_rd_en, 0);
    chk({pfx, "_dst_wr_en"}, dst_wr_en, 0);
    chk({pfx, "_dst_addr"}, dst_addr, 0);
    chk({pfx, "_dst_wr_data"}, dst_wr_data, 0);
  endtask

  task automatic model_clear();
    phase = 0; reads = 0; pushes = 0; pops = 0; writes = 0;
    wr_pending = 1'b0; last_iss = -10; wr_idx = 0; wr_val = '0;
  endtask

  // One clock cycle: sample and compare at the falling edge, advance the
  // model, then drive the next inputs just after the rising edge.
  task automatic cycle();
    bit run, e_push, e_rd, e_pop, stall, avail, extra;
    int o, nphase;
    @(negedge clock);
    if (!reset) begin
      chk_all_zero("rst");
      model_clear();
      nxt_src = RW'($urandom);
    end else begin
      run    = (phase == 1);
      o      = reads - pushes;
      e_push = run && (o > 0) && !fifo_rgb_full;
      e_rd   = run && (reads < N) &&
               ((o == 0) || ((o == 1) && (last_iss == cyc - 1) && !fifo_rgb_full));
      e_pop  = run && !fifo_sobel_empty && (pops < N);

      chk("busy", busy, phase != 0);
      chk("done", done, phase == 2);
      chk("src_rd_en", src_rd_en, e_rd);
      chk("rgb_wr_en", fifo_rgb_wr_en, e_push);
      chk("sobel_rd_en", fifo_sobel_rd_en, e_pop);
      chk("dst_wr_en", dst_wr_en, wr_pending);
      if (e_rd && src_rd_en) chk("src_addr", src_addr, reads);
      if (e_push && fifo_rgb_wr_en) chk("rgb_din", fifo_rgb_din, src_mem[pushes]);
      if (wr_pending && dst_wr_en) begin
        chk("dst_addr", dst_addr, wr_idx);
        chk("dst_wr_data", dst_wr_data, wr_val);
      end

      if (src_rd_en) begin
        if (f_first_rd < 0) begin
          f_first_rd = cyc;
          f_first_addr = int'(src_addr);
        end
        f_last_rd = cyc;
        f_rd++;
      end
      if (fifo_rgb_wr_en && f_first_push < 0) f_first_push = cyc;
      if (dst_wr_en) begin
        f_wr++;
        f_last_wdata = dst_wr_data;
      end
      if (done) begin
        f_done++;
        f_done_cyc = cyc;
      end

      // Source memory answers the DUT's actual request; garbage otherwise.
      nxt_src = (src_rd_en && int'(src_addr) < N) ? src_mem[int'(src_addr)] : RW'($urandom);

      nphase = phase;
      if (e_push) pushes++;
      if (e_rd) begin
        reads++;
        last_iss = cyc;
      end
      if (wr_pending) begin
        writes++;
        if (writes == N) nphase = 2;
      end
      wr_pending = e_pop;
      if (e_pop) begin
        wr_idx = pops;
        wr_val = sob_mem[pops];
        pops++;
      end
      if (phase == 0 && start) begin
        nphase = 1;
        reads = 0; pushes = 0; pops = 0; writes = 0; wr_pending = 1'b0;
        f_start_cyc = cyc;
      end
      if (phase == 2) nphase = 0;
      phase = nphase;
    end

    if (!reset) begin
      nxt_full  = 1'b0;
      nxt_empty = 1'b1;
      nxt_dout  = SW'($urandom);
    end else begin
      nxt_full = ((cyc + 1 >= force_lo) && (cyc + 1 <= force_hi)) ||
                 ($urandom_range(0, 99) < full_pct);
      // Results only exist for pixels already pushed; once the frame's
      // results are consumed the FIFO shows stray extra data.
      avail = (pops < pushes);
      extra = (pops >= N);
      stall = empty_tog ? ((cyc + 1) % 2 == 1) : ($urandom_range(0, 99) < empty_pct);
      nxt_empty = extra ? 1'b0 : !(avail && !stall);
      nxt_dout  = (!nxt_empty && !extra) ? sob_mem[pops] : SW'($urandom);
    end
    cyc++;
    @(posedge clock);
    #1;
    src_rd_data      = nxt_src;
    fifo_rgb_full    = nxt_full;
    fifo_sobel_empty = nxt_empty;
    fifo_sobel_dout  = nxt_dout;
  endtask

  task automatic setup_frame(input bit addr_data, input bit sob_a0, input int fpct,
                             input int epct, input bit etog, input int force_off);
    for (int i = 0; i < N; i++) begin
      src_mem[i] = addr_data ? RW'(i) : RW'($urandom);
      sob_mem[i] = sob_a0 ? SW'(8'hA0 + i) : SW'($urandom);
    end
    full_pct  = fpct;
    empty_pct = epct;
    empty_tog = etog;
    if (force_off >= 0) begin
      force_lo = cyc + force_off;
      force_hi = cyc + force_off + 4;
    end else begin
      force_lo = -10;
      force_hi = -20;
    end
    f_rd = 0; f_wr = 0; f_done = 0; f_first_rd = -1; f_last_rd = -1;
    f_first_push = -1; f_done_cyc = -1; f_first_addr = -1; f_last_wdata = '0;
  endtask

  task automatic run_frame(input bit addr_data, input bit sob_a0, input int fpct,
                           input int epct, input bit etog, input int force_off, input bit rstart);
    int i;
    setup_frame(addr_data, sob_a0, fpct, epct, etog, force_off);
    start = 1'b1;
    cycle();
    start = 1'b0;
    i = 0;
    while (phase != 0 && i < 3000) begin
      start = rstart && ($urandom_range(0, 3) == 0);
      cycle();
      start = 1'b0;
      i++;
    end
    if (phase != 0) begin
      chk("frame_timeout", phase, 0);
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      cycle();
    end
    chk("frame_reads", f_rd, N);
    chk("frame_writes", f_wr, N);
    chk("frame_done_pulses", f_done, 1);
  endtask

  task automatic abort_frame();
    int i;
    setup_frame(1'b1, 1'b0, 0, 30, 1'b0, -1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    i = 0;
    while (reads < 8 && i < 200) begin
      cycle();
      i++;
    end
    chk("abort_reached_read7", reads >= 8, 1);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("arst");
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    src_rd_data = '0;
    fifo_rgb_full = 1'b0;
    fifo_sobel_empty = 1'b1;
    fifo_sobel_dout = '0;
    model_clear();
    full_pct = 0; empty_pct = 0; empty_tog = 1'b0; force_lo = -10; force_hi = -20;
    repeat (3) cycle();
    reset = 1'b1;
    repeat (2) cycle();

    // Unblocked frame, data = address; latencies pinned by hand.
    run_frame(1'b1, 1'b1, 0, 0, 1'b0, -1, 1'b0);
    chk("f1_first_rd_latency", f_first_rd - f_start_cyc, 1);
    chk("f1_rd_span", f_last_rd - f_first_rd, 15);
    chk("f1_first_push_latency", f_first_push - f_start_cyc, 2);
    chk("f1_done_latency", f_done_cyc - f_start_cyc, 20);
    chk("f1_last_wdata", f_last_wdata, 8'hAF);
    repeat (3) cycle();

    // RGB FIFO full for 5 cycles while a read is in flight.
    run_frame(1'b1, 1'b0, 0, 0, 1'b0, 4, 1'b0);

    // Sobel FIFO empty every other cycle, results 0xA0+index.
    run_frame(1'b0, 1'b1, 0, 0, 1'b1, -1, 1'b0);
    chk("f3_last_wdata", f_last_wdata, 8'hAF);

    // Stray start pulses during RUN/DONE.
    run_frame(1'b0, 1'b0, 20, 20, 1'b0, -1, 1'b1);

    // Abort mid-frame, then a fresh frame must start at address 0.
    abort_frame();
    run_frame(1'b0, 1'b0, 10, 10, 1'b0, -1, 1'b0);
    chk("after_reset_first_addr", f_first_addr, 0);

    // Randomised frames, mostly back-to-back.
    for (int k = 0; k < 12; k++) begin
      run_frame(1'b0, 1'b0, int'($urandom_range(0, 60)), int'($urandom_range(0, 60)),
                1'b0, -1, 1'($urandom_range(0, 1)));
      if (k % 3 == 0) repeat ($urandom_range(0, 3)) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
